// File: rtl/regfile_pkg.sv
// Shared defaults, level constants and clear-sequencer state encoding for regfile_2r1w.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_D_DEF = 32;

    localparam logic HIGH     = 1'b1;
    localparam logic LOW      = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: sweeps every entry once per accepted clr_req and drives a
// per-cycle clear strobe and address into the array.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_D = DATA_D_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DATA_D - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= LOW;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // clr_req is only sampled in IDLE, so a held level cannot restart a running sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req == HIGH) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == CLEAR) ? HIGH : LOW;
    end

    always_comb begin
        busy     = busy_q;
        clr_we   = (state_q == CLEAR) ? HIGH : LOW;
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with registered, write-first bypassed reads
// and a hardware clear sweep. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_D = DATA_D_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              we_,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              clr_req,
    output logic              busy
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(DATA_D);

    logic [DATA_W-1:0]            mem_q [DATA_D];
    logic [DATA_W-1:0]            mem_d [DATA_D];
    logic [1:0][DATA_W-1:0]       rd_q, rd_d;
    logic [1:0][ADDR_W-1:0]       rd_addr;
    logic                         clr_we;
    logic [ADDR_W-1:0]            clr_addr;
    logic                         wr_blocked;
    logic                         wr_acc;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH);
    endfunction

    regfile_clr_seq #(
        .ADDR_W (ADDR_W),
        .DATA_D (DATA_D)
    ) u_clr_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

`ifdef REGFILE_ZERO_REG_EN
    assign wr_blocked = (wr_addr == '0);
`else
    assign wr_blocked = LOW;
`endif

    assign rd_addr = {rd1_addr, rd0_addr};

    always_comb begin
        wr_acc = (clr_we == LOW) && (we_ == ENABLE_) && in_range(wr_addr) && !wr_blocked;
    end

    // Sweep and external writes are mutually exclusive: writes are only accepted in IDLE.
    always_comb begin
        mem_d = mem_q;
        if (clr_we == HIGH) begin
            mem_d[clr_addr] = '0;
        end
        if (wr_acc) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        rd_d = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            if (in_range(rd_addr[p])) begin
                rd_d[p] = mem_q[rd_addr[p]];
            end
            if (wr_acc && (wr_addr == rd_addr[p])) begin
                rd_d[p] = wr_data;
            end
            if ((clr_we == HIGH) && (clr_addr == rd_addr[p])) begin
                rd_d[p] = '0;
            end
`ifdef REGFILE_ZERO_REG_EN
            if (rd_addr[p] == '0) begin
                rd_d[p] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < unsigned'(DATA_D); i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
        end
    end

    assign rd0_data = rd_q[0];
    assign rd1_data = rd_q[1];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: a behavioural model predicts each cycle's
// read data and busy, queues the prediction, and checks it after the edge.
module tb_regfile_2r1w;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DD = 32;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          we_ = 1'b0;
    logic [AW-1:0] rd0_addr = '0;
    logic [AW-1:0] rd1_addr = '0;
    logic          clr_req = 1'b0;
    logic [DW-1:0] rd0_data;
    logic [DW-1:0] rd1_data;
    logic          busy;

    regfile_2r1w #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DATA_D (DD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .we_      (we_),
        .rd0_addr (rd0_addr),
        .rd0_data (rd0_data),
        .rd1_addr (rd1_addr),
        .rd1_data (rd1_data),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
        logic          b;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] mdl_mem [DD];
    bit            mdl_clr = 1'b0;
    int unsigned   mdl_cnt = 0;
    int            n_checks = 0;
    int            n_fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a, input bit acc);
        if (ZERO_EN && a == '0) return '0;
        if (acc && a == wr_addr) return wr_data;
        if (mdl_clr && int'(a) == int'(mdl_cnt)) return '0;
        return mdl_mem[a];
    endfunction

    task automatic step();
        bit   acc;
        exp_t e;
        acc  = !mdl_clr && (we_ == 1'b0) && !(ZERO_EN && wr_addr == '0);
        e.r0 = mdl_read(rd0_addr, acc);
        e.r1 = mdl_read(rd1_addr, acc);
        if (mdl_clr) mdl_mem[mdl_cnt] = '0;
        if (acc) mdl_mem[wr_addr] = wr_data;
        if (mdl_clr) begin
            if (mdl_cnt == DD - 1) begin
                mdl_clr = 1'b0;
                mdl_cnt = 0;
            end else begin
                mdl_cnt++;
            end
        end else if (clr_req) begin
            mdl_clr = 1'b1;
            mdl_cnt = 0;
        end
        e.b = mdl_clr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
        e = sb_q.pop_front();
        check_eq("rd0_data", rd0_data, e.r0);
        check_eq("rd1_data", rd1_data, e.r1);
        check_eq("busy", 32'(busy), 32'(e.b));
    endtask

    task automatic cyc(input logic we_n, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic clr);
        we_      = we_n;
        wr_addr  = wa;
        wr_data  = wd;
        rd0_addr = r0;
        rd1_addr = r1;
        clr_req  = clr;
        step();
    endtask

    task automatic do_reset_async();
        reset = 1'b1;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd0", rd0_data, 32'd0);
        check_eq("rst_rd1", rd1_data, 32'd0);
        for (int i = 0; i < DD; i++) mdl_mem[i] = '0;
        mdl_clr = 1'b0;
        mdl_cnt = 0;
        @(negedge clk);
        reset   = 1'b0;
        we_     = DISABLE_;
        clr_req = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < DD; a++) cyc(DISABLE_, '0, '0, AW'(a), AW'(DD - 1 - a), 1'b0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DD; i++)
            cyc(ENABLE_, AW'(i), $urandom, AW'($urandom_range(DD - 1)), AW'($urandom_range(DD - 1)), 1'b0);
    endtask

    initial begin
        int busy_cnt;
        for (int i = 0; i < DD; i++) mdl_mem[i] = '0;
        #2;
        do_reset_async();
        read_all();

        for (int i = 0; i < DD; i++) begin
            cyc(ENABLE_, AW'(i), DW'(i), AW'(i), AW'(DD - 1 - i), 1'b0);
            cyc(DISABLE_, '0, '0, AW'(i), AW'(DD - 1 - i), 1'b0);
        end

        cyc(ENABLE_, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 1'b0);
        cyc(DISABLE_, '0, '0, 5'd7, 5'd7, 1'b0);

        // Single-cycle clear pulse with a dropped write at sweep count 3
        fill_random();
        cyc(DISABLE_, '0, '0, '0, '0, 1'b1);
        busy_cnt = busy ? 1 : 0;
        for (int k = 0; k < 40 && busy; k++) begin
            if (mdl_cnt == 3)
                cyc(ENABLE_, 5'd31, 32'h55, 5'd31, AW'(mdl_cnt), 1'b0);
            else
                cyc(DISABLE_, '0, '0, AW'(mdl_cnt), AW'($urandom_range(DD - 1)), 1'b0);
            if (busy) busy_cnt++;
        end
        check_eq("busy_cycles", 32'(busy_cnt), 32'd32);
        read_all();

        // Write and clear request on the same edge, then clr_req held across the sweep end
        fill_random();
        cyc(ENABLE_, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b1);
        for (int k = 0; k < 34; k++) cyc(DISABLE_, '0, '0, 5'd5, AW'(mdl_cnt), 1'b1);
        for (int k = 0; k < 40 && busy; k++) cyc(DISABLE_, '0, '0, 5'd5, AW'(k), 1'b0);
        check_eq("restart_idle", 32'(busy), 32'd0);
        read_all();

        // Asynchronous reset in the middle of a sweep
        fill_random();
        cyc(DISABLE_, '0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 20 && mdl_cnt != 10; k++) cyc(DISABLE_, '0, '0, 5'd20, 5'd30, 1'b0);
        do_reset_async();
        read_all();

        cyc(ENABLE_, '0, 32'hFF, 5'd1, 5'd2, 1'b0);
        cyc(DISABLE_, '0, '0, '0, '0, 1'b0);
        cyc(ENABLE_, '0, 32'h1234, '0, 5'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
